// File: rtl/oled_spi_byte_tx_pkg.sv
// rtl/oled_spi_byte_tx_pkg.sv - shared SSD1309 OLED constants, state codes and byte record
package oled_spi_byte_tx_pkg;

    // Serializer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // Default SCLK / CS timing in clk cycles (27 MHz / 8 = 3.375 MHz SCLK)
    localparam int DEF_HALF_PERIOD = 4;
    localparam int DEF_CS_SETUP    = 2;
    localparam int DEF_CS_HOLD     = 2;

    // SSD1309 command bytes used by the init sequencer
    localparam logic [7:0] SSD1309_DISPLAY_OFF = 8'hAE;
    localparam logic [7:0] SSD1309_DISPLAY_ON  = 8'hAF;
    localparam logic [7:0] SSD1309_ENTIRE_ON   = 8'hA5;

    // One queued byte with its D/C flag and CS-release marker
    typedef struct packed {
        logic [7:0] data;
        logic       dc;
        logic       last;
    } oled_byte_t;

endpackage

// File: rtl/oled_spi_byte_tx_if.sv
// rtl/oled_spi_byte_tx_if.sv - byte handshake between the sequencer and the SPI serializer
interface oled_spi_byte_tx_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_dc;
    logic       in_last;

    modport master (
        output in_valid,
        output in_data,
        output in_dc,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_dc,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/oled_spi_byte_tx_sclk_gen.sv
// rtl/oled_spi_byte_tx_sclk_gen.sv - half-period counter producing SCLK and its falling strobe
module oled_spi_byte_tx_sclk_gen
    import oled_spi_byte_tx_pkg::*;
#(
    parameter int HALF_PERIOD = DEF_HALF_PERIOD
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run_i,
    output logic sclk_o,
    output logic fall_o
);

    localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          sclk_q, sclk_d;
    logic          half_done;
    logic          rise;

    assign half_done = run_i && (hcnt_q == HW'(HALF_PERIOD - 1));
    assign rise      = half_done & ~sclk_q;
    assign fall_o    = half_done & sclk_q;
    assign sclk_o    = sclk_q;

    // Count out each half period; every bit starts with a low phase when run rises
    always_comb begin
        hcnt_d = hcnt_q;
        sclk_d = sclk_q;
        if (!run_i) begin
            hcnt_d = '0;
            sclk_d = 1'b0;
        end else if (half_done) begin
            hcnt_d = '0;
            sclk_d = rise ? 1'b1 : 1'b0;
        end else begin
            hcnt_d = hcnt_q + HW'(1);
        end
    end

    // SCLK and phase counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_q <= '0;
            sclk_q <= 1'b0;
        end else begin
            hcnt_q <= hcnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/oled_spi_byte_tx.sv
// rtl/oled_spi_byte_tx.sv - write-only SSD1309 4-wire SPI byte serializer (mode 0, MSB first)
module oled_spi_byte_tx
    import oled_spi_byte_tx_pkg::*;
#(
    parameter int HALF_PERIOD = DEF_HALF_PERIOD,
    parameter int CS_SETUP    = DEF_CS_SETUP,
    parameter int CS_HOLD     = DEF_CS_HOLD
) (
    input  logic                 clk,
    input  logic                 reset_n,
    oled_spi_byte_tx_if.slave    in_if,
    output logic                 busy,
    output logic                 sclk,
    output logic                 sdin,
    output logic                 cs,
    output logic                 dc
);

    localparam int TMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int TW   = $clog2(TMAX + 1);

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          last_q, last_d;
    logic          dc_q, dc_d;
    logic          sdin_q, sdin_d;
    logic          cs_q, cs_d;
    oled_byte_t    hold_q, hold_d;
    logic          hold_valid_q, hold_valid_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;
    logic          accept;
    logic          load;
    logic          fall;

    oled_spi_byte_tx_sclk_gen #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_sclk_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .run_i   (state_q == ST_SHIFT),
        .sclk_o  (sclk),
        .fall_o  (fall)
    );

    assign accept         = in_if.in_valid & in_ready_q;
    assign in_if.in_ready = in_ready_q;
    assign busy           = busy_q;
    assign sdin           = sdin_q;
    assign cs             = cs_q;
    assign dc             = dc_q;

    // Sequence CS framing, bit shifting and the single-entry holding register
    always_comb begin
        state_d      = state_q;
        tcnt_d       = tcnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        last_d       = last_q;
        dc_d         = dc_q;
        sdin_d       = sdin_q;
        cs_d         = cs_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        load         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cs_d = 1'b1;
                if (hold_valid_q) begin
                    load    = 1'b1;
                    cs_d    = 1'b0;
                    tcnt_d  = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tcnt_q == TW'(CS_SETUP - 1)) begin
                    tcnt_d  = '0;
                    bit_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            ST_SHIFT: begin
                if (fall) begin
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
                        // Chain straight into the next byte only if it was already waiting
                        if (!last_q && hold_valid_q) begin
                            load = 1'b1;
                        end else begin
                            tcnt_d  = '0;
                            state_d = ST_HOLD;
                        end
                    end else begin
                        shift_d = {shift_q[6:0], 1'b0};
                        sdin_d  = shift_q[6];
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (tcnt_q == TW'(CS_HOLD - 1)) begin
                    tcnt_d  = '0;
                    cs_d    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: begin
                cs_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            shift_d = hold_q.data;
            sdin_d  = hold_q.data[7];
            dc_d    = hold_q.dc;
            last_d  = hold_q.last;
        end

        // Capture and load never coincide: load needs a full register, capture an empty one
        if (load) begin
            hold_valid_d = 1'b0;
        end else if (accept) begin
            hold_valid_d = 1'b1;
            hold_d       = '{data: in_if.in_data, dc: in_if.in_dc, last: in_if.in_last};
        end

        in_ready_d = ~hold_valid_d;
        busy_d     = (state_d != ST_IDLE) | hold_valid_d;
    end

    // State and output registers; reset releases CS at once and drops any partial byte
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            tcnt_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            last_q       <= 1'b0;
            dc_q         <= 1'b0;
            sdin_q       <= 1'b0;
            cs_q         <= 1'b1;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tcnt_q       <= tcnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            last_q       <= last_d;
            dc_q         <= dc_d;
            sdin_q       <= sdin_d;
            cs_q         <= cs_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
        end
    end

endmodule
